// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
// Shared constants for the RISC-V integer register file.
//   DATA_WIDTH_32  : width of one architectural register
//   REGISTER_NUM   : number of architectural registers
//   REG_ADDR_WIDTH : register index width (clog2 of REGISTER_NUM)
//   ZERO_REG       : index of the hardwired-zero register x0
// Optional feature macro used by the register file: REGFILE_WRITE_BYPASS_EN
// -----------------------------------------------------------------------------
package register_file_pkg;

    localparam int DATA_WIDTH_32  = 32;
    localparam int REGISTER_NUM   = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

    // True when the given index names x0, which never holds a value.
    function automatic logic isZeroReg(input logic [REG_ADDR_WIDTH-1:0] index);
        return (index == ZERO_REG);
    endfunction

endpackage

// File: rtl/register_file_read_port.sv
// -----------------------------------------------------------------------------
// register_file_read_port
// One combinational read port of the register file: selects a register from
// the flattened storage array and forces 0 when x0 is addressed.
// Ports:
//   regArray    (in)  : current register contents, one row per register
//   readIndex   (in)  : register index to read (rs1 or rs2)
//   writeEnable (in)  : write strobe        (only with REGFILE_WRITE_BYPASS_EN)
//   writeIndex  (in)  : write index (rd)    (only with REGFILE_WRITE_BYPASS_EN)
//   writeData   (in)  : data being written  (only with REGFILE_WRITE_BYPASS_EN)
//   readData    (out) : selected register value
// Macro: REGFILE_WRITE_BYPASS_EN enables write-first forwarding of writeData.
// -----------------------------------------------------------------------------
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_32,
    parameter int REGISTER_NUM = register_file_pkg::REGISTER_NUM,
    parameter int ADDR_WIDTH   = REG_ADDR_WIDTH
) (
    input  logic [REGISTER_NUM-1:0][DATA_WIDTH-1:0] regArray,
    input  logic [ADDR_WIDTH-1:0]                   readIndex,
`ifdef REGFILE_WRITE_BYPASS_EN
    input  logic                                    writeEnable,
    input  logic [ADDR_WIDTH-1:0]                   writeIndex,
    input  logic [DATA_WIDTH-1:0]                   writeData,
`endif
    output logic [DATA_WIDTH-1:0]                   readData
);

    // Read mux: x0 is forced to zero explicitly rather than trusting storage.
    always_comb begin
        readData = regArray[readIndex];
        if (isZeroReg(readIndex)) begin
            readData = '0;
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        // Forward the in-flight write so the reader sees it before the edge.
        else if (writeEnable && (writeIndex == readIndex)) begin
            readData = writeData;
        end
`endif
        else begin
            readData = regArray[readIndex];
        end
    end

endmodule

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// 32 x 32-bit RISC-V integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero, asynchronous active-low reset.
// Ports:
//   clk          (in)  : core clock, writes on the rising edge
//   rst_n        (in)  : asynchronous active-low reset, clears all registers
//   srcRegister1 (in)  : read port 1 index (rs1)
//   srcRegister2 (in)  : read port 2 index (rs2)
//   writeEnable  (in)  : write strobe
//   desRegister  (in)  : write index (rd); writes to x0 are dropped
//   writeData    (in)  : data to write
//   readData1    (out) : contents of srcRegister1
//   readData2    (out) : contents of srcRegister2
// Macro: REGFILE_WRITE_BYPASS_EN -> read ports forward writeData on an index
// match (write-first); undefined -> reads return the old value until the edge.
// ADDR_WIDTH must equal clog2(REGISTER_NUM) so every index is in range.
// -----------------------------------------------------------------------------
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_32,
    parameter int REGISTER_NUM = register_file_pkg::REGISTER_NUM,
    parameter int ADDR_WIDTH   = REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] srcRegister1,
    input  logic [ADDR_WIDTH-1:0] srcRegister2,
    input  logic                  writeEnable,
    input  logic [ADDR_WIDTH-1:0] desRegister,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    logic [REGISTER_NUM-1:0][DATA_WIDTH-1:0] regArray_r;
    logic                                    writeHit_s;

    // A write only lands when strobed and not aimed at x0.
    always_comb begin
        if (writeEnable && !isZeroReg(desRegister)) begin
            writeHit_s = 1'b1;
        end else begin
            writeHit_s = 1'b0;
        end
    end

    // Register storage: async clear, single synchronous write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regArray_r <= '0;
        end else if (writeHit_s) begin
            regArray_r[desRegister] <= writeData;
        end
    end

    register_file_read_port #(
        .DATA_WIDTH   (DATA_WIDTH),
        .REGISTER_NUM (REGISTER_NUM),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) readPort1 (
        .regArray    (regArray_r),
        .readIndex   (srcRegister1),
`ifdef REGFILE_WRITE_BYPASS_EN
        .writeEnable (writeEnable),
        .writeIndex  (desRegister),
        .writeData   (writeData),
`endif
        .readData    (readData1)
    );

    register_file_read_port #(
        .DATA_WIDTH   (DATA_WIDTH),
        .REGISTER_NUM (REGISTER_NUM),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) readPort2 (
        .regArray    (regArray_r),
        .readIndex   (srcRegister2),
`ifdef REGFILE_WRITE_BYPASS_EN
        .writeEnable (writeEnable),
        .writeIndex  (desRegister),
        .writeData   (writeData),
`endif
        .readData    (readData2)
    );

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
// Self-checking bench for register_file against an array-based reference model.
// Honours REGFILE_WRITE_BYPASS_EN when predicting pre-edge read values.
// -----------------------------------------------------------------------------
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  srcRegister1;
    logic [4:0]  srcRegister2;
    logic        writeEnable;
    logic [4:0]  desRegister;
    logic [31:0] writeData;
    logic [31:0] readData1;
    logic [31:0] readData2;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: architectural register contents.
    logic [31:0] model [32];

    register_file dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .srcRegister1 (srcRegister1),
        .srcRegister2 (srcRegister2),
        .writeEnable  (writeEnable),
        .desRegister  (desRegister),
        .writeData    (writeData),
        .readData1    (readData1),
        .readData2    (readData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] modelRead(input int idx);
        return (idx == 0) ? 32'd0 : model[idx];
    endfunction

    // Value a read port should show before the edge while a write is pending.
    function automatic logic [31:0] preEdgeRead(input int src, input logic we,
                                                input int des, input logic [31:0] wd);
`ifdef REGFILE_WRITE_BYPASS_EN
        if (src != 0 && we && des == src) return wd;
`endif
        return modelRead(src);
    endfunction

    // Apply one write over a rising edge and mirror it into the model.
    task automatic doWrite(input int idx, input logic [31:0] data);
        @(negedge clk);
        desRegister = idx[4:0];
        writeData   = data;
        writeEnable = 1'b1;
        @(posedge clk);
        if (rst_n && idx != 0) model[idx] = data;
        #1;
        writeEnable = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        writeEnable = 1'b0;
        desRegister = 5'd0;
        writeData = 32'd0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        #2;
        for (int i = 0; i < 32; i++) begin
            srcRegister1 = i[4:0];
            srcRegister2 = 5'(31 - i);
            #1;
            compared += 2;
            if (readData1 !== 32'd0) begin
                mismatched++;
                $display("FAIL reset_rd1 idx=%0d got=%h exp=00000000", i, readData1);
            end
            if (readData2 !== 32'd0) begin
                mismatched++;
                $display("FAIL reset_rd2 idx=%0d got=%h exp=00000000", 31 - i, readData2);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_sweep();
        for (int i = 0; i < 32; i++) begin
            doWrite(i, 32'(i + 1));
            srcRegister1 = i[4:0];
            srcRegister2 = i[4:0];
            #1;
            compared += 2;
            if (readData1 !== ((i == 0) ? 32'd0 : 32'(i + 1))) begin
                mismatched++;
                $display("FAIL sweep_rd1 idx=%0d got=%h exp=%h", i, readData1,
                         (i == 0) ? 32'd0 : 32'(i + 1));
            end
            if (readData2 !== ((i == 0) ? 32'd0 : 32'(i + 1))) begin
                mismatched++;
                $display("FAIL sweep_rd2 idx=%0d got=%h exp=%h", i, readData2,
                         (i == 0) ? 32'd0 : 32'(i + 1));
            end
        end
    endtask

    task automatic test_x0();
        doWrite(0, 32'hDEADBEEF);
        srcRegister1 = 5'd0;
        srcRegister2 = 5'd0;
        #1;
        compared += 2;
        if (readData1 !== 32'd0) begin
            mismatched++;
            $display("FAIL x0_rd1 got=%h exp=00000000", readData1);
        end
        if (readData2 !== 32'd0) begin
            mismatched++;
            $display("FAIL x0_rd2 got=%h exp=00000000", readData2);
        end
    endtask

    task automatic test_same_cycle_timing();
        logic [31:0] expBefore;
        @(negedge clk);
        srcRegister1 = 5'd5;
        desRegister  = 5'd5;
        writeData    = 32'h12345678;
        writeEnable  = 1'b1;
        expBefore    = preEdgeRead(5, 1'b1, 5, 32'h12345678);
        #1;
        compared++;
        if (readData1 !== expBefore) begin
            mismatched++;
            $display("FAIL timing_before got=%h exp=%h", readData1, expBefore);
        end
        @(posedge clk);
        model[5] = 32'h12345678;
        #1;
        writeEnable = 1'b0;
        #1;
        compared++;
        if (readData1 !== 32'h12345678) begin
            mismatched++;
            $display("FAIL timing_after got=%h exp=12345678", readData1);
        end
    endtask

    task automatic test_dual_port();
        doWrite(3, 32'hA5A5A5A5);
        doWrite(7, 32'h5A5A5A5A);
        srcRegister1 = 5'd3;
        srcRegister2 = 5'd7;
        #1;
        compared += 2;
        if (readData1 !== 32'hA5A5A5A5) begin
            mismatched++;
            $display("FAIL dual_rd1 got=%h exp=a5a5a5a5", readData1);
        end
        if (readData2 !== 32'h5A5A5A5A) begin
            mismatched++;
            $display("FAIL dual_rd2 got=%h exp=5a5a5a5a", readData2);
        end
    endtask

    task automatic test_enable_gating();
        @(negedge clk);
        writeEnable = 1'b0;
        writeData   = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            desRegister = (k % 2 == 0) ? 5'd3 : 5'd7;
            @(posedge clk);
        end
        #1;
        compared += 2;
        if (readData1 !== 32'hA5A5A5A5) begin
            mismatched++;
            $display("FAIL gate_x3 got=%h exp=a5a5a5a5", readData1);
        end
        if (readData2 !== 32'h5A5A5A5A) begin
            mismatched++;
            $display("FAIL gate_x7 got=%h exp=5a5a5a5a", readData2);
        end
    endtask

    task automatic test_random();
        int des, s1, s2;
        logic we;
        logic [31:0] wd, e1, e2;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            we  = 1'($urandom_range(1, 0));
            des = $urandom_range(31, 0);
            wd  = $urandom;
            s1  = $urandom_range(31, 0);
            s2  = (n % 5 == 0) ? des : $urandom_range(31, 0);
            writeEnable  = we;
            desRegister  = des[4:0];
            writeData    = wd;
            srcRegister1 = s1[4:0];
            srcRegister2 = s2[4:0];
            e1 = preEdgeRead(s1, we, des, wd);
            e2 = preEdgeRead(s2, we, des, wd);
            #1;
            compared += 2;
            if (readData1 !== e1) begin
                mismatched++;
                $display("FAIL rand_rd1 n=%0d src=%0d got=%h exp=%h", n, s1, readData1, e1);
            end
            if (readData2 !== e2) begin
                mismatched++;
                $display("FAIL rand_rd2 n=%0d src=%0d got=%h exp=%h", n, s2, readData2, e2);
            end
            @(posedge clk);
            if (we && des != 0) model[des] = wd;
        end
        @(negedge clk);
        writeEnable = 1'b0;
        for (int i = 0; i < 32; i++) begin
            srcRegister1 = i[4:0];
            #1;
            compared++;
            if (readData1 !== modelRead(i)) begin
                mismatched++;
                $display("FAIL rand_final idx=%0d got=%h exp=%h", i, readData1, modelRead(i));
            end
        end
    endtask

    task automatic test_async_reset();
        doWrite(3, 32'hA5A5A5A5);
        doWrite(7, 32'h5A5A5A5A);
        srcRegister1 = 5'd3;
        srcRegister2 = 5'd7;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compared += 2;
        if (readData1 !== 32'd0) begin
            mismatched++;
            $display("FAIL arst_rd1 got=%h exp=00000000", readData1);
        end
        if (readData2 !== 32'd0) begin
            mismatched++;
            $display("FAIL arst_rd2 got=%h exp=00000000", readData2);
        end
        // A write strobed while reset is held must be ignored.
        desRegister = 5'd9;
        writeData   = 32'hCAFEF00D;
        writeEnable = 1'b1;
        @(posedge clk);
        #1;
        writeEnable = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            srcRegister1 = i[4:0];
            srcRegister2 = 5'(31 - i);
            #1;
            compared += 2;
            if (readData1 !== 32'd0) begin
                mismatched++;
                $display("FAIL post_arst_rd1 idx=%0d got=%h exp=00000000", i, readData1);
            end
            if (readData2 !== 32'd0) begin
                mismatched++;
                $display("FAIL post_arst_rd2 idx=%0d got=%h exp=00000000", 31 - i, readData2);
            end
        end
    endtask

    initial begin
        srcRegister1 = 5'd0;
        srcRegister2 = 5'd0;
        test_reset();
        test_write_sweep();
        test_x0();
        test_same_cycle_timing();
        test_dual_port();
        test_enable_gating();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
